// File: rtl/prog_loader.sv
// Host-to-memory program loader: splits 32-bit instruction words into four
// little-endian byte writes and holds the CPU in reset while loading.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] word_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WR0    = 3'd2;
    localparam logic [2:0] S_WR1    = 3'd3;
    localparam logic [2:0] S_WR2    = 3'd4;
    localparam logic [2:0] S_WR3    = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    // One extra address bit so the pointer can reach 2^ADDR_W after the top
    // word instead of wrapping back to 0 and passing the overflow check.
    localparam logic [ADDR_W:0]   BASE     = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_OK  = (ADDR_W+1)'((2 ** ADDR_W) - 4);
    localparam logic [ADDR_W:0]   ADDR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W-1)'(1);

    logic [2:0]      state;
    logic [ADDR_W:0] addr;
    logic [31:0]     word_q;
    logic            last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before this edge.
            state    <= S_IDLE;
            addr     <= BASE;
            word_q   <= '0;
            last_q   <= 1'b0;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCEPT;
                        addr     <= BASE;
                        word_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (word_valid) begin
                        if (addr <= LAST_OK) begin
                            word_q <= word_data;
                            last_q <= word_last;
                            state  <= S_WR0;
                        end else begin
                            // No room for four more bytes: drop the word and end.
                            err   <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_WR0: begin
                    addr  <= addr + ADDR_ONE;
                    state <= S_WR1;
                end
                S_WR1: begin
                    addr  <= addr + ADDR_ONE;
                    state <= S_WR2;
                end
                S_WR2: begin
                    addr  <= addr + ADDR_ONE;
                    state <= S_WR3;
                end
                S_WR3: begin
                    addr     <= addr + ADDR_ONE;
                    word_cnt <= word_cnt + CNT_ONE;
                    state    <= last_q ? S_FIN : S_ACCEPT;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the state register only, so reset clears them
    // asynchronously and word_valid never reaches mem_we combinationally.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned and infers a latch.
        word_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_ACCEPT: begin
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                word_ready = 1'b1;
            end
            S_WR0, S_WR1, S_WR2, S_WR3: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr[ADDR_W-1:0];
                case (state)
                    S_WR0:   mem_wdata = word_q[7:0];
                    S_WR1:   mem_wdata = word_q[15:8];
                    S_WR2:   mem_wdata = word_q[23:16];
                    default: mem_wdata = word_q[31:24];
                endcase
            end
            S_FIN: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance at BASE_ADDR=0 and one at 248
// share the word stream; byte writes are logged and compared to hand values.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    bit          sel;

    logic       ready0, we0, hold0, busy0, done0, err0;
    logic [7:0] addr0, wdata0;
    logic [6:0] cnt0;
    logic       ready1, we1, hold1, busy1, done1, err1;
    logic [7:0] addr1, wdata1;
    logic [6:0] cnt1;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(ready0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0), .word_cnt(cnt0)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(248)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(ready1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1), .word_cnt(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  a;
        logic [7:0]  d;
    } wr_t;

    wr_t log0[$];
    wr_t log1[$];
    int  cyc = 0;
    int  done_cnt0 = 0;
    int  done_cnt1 = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we0) log0.push_back('{cyc: cyc, a: addr0, d: wdata0});
        if (we1) log1.push_back('{cyc: cyc, a: addr1, d: wdata1});
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the selected loader shows word_ready;
    // returns one cycle after the handshake edge.
    task automatic send_word(input logic [31:0] w, input logic l);
        int n = 0;
        word_valid = 1'b1;
        word_data  = w;
        word_last  = l;
        while (!(sel ? ready1 : ready0) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        step();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    // Four logged writes starting at log index idx must carry word w, LSB first.
    task automatic check_word(input bit which, input int idx, input logic [7:0] base,
                              input logic [31:0] w);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (idx + k < (which ? log1.size() : log0.size())) begin
                e = which ? log1[idx + k] : log0[idx + k];
                check($sformatf("wr%0d_addr", idx + k), {24'd0, e.a}, {24'd0, base + 8'(k)});
                check($sformatf("wr%0d_data", idx + k), {24'd0, e.d}, {24'd0, w[8*k +: 8]});
            end else begin
                check($sformatf("wr%0d_missing", idx + k), 32'd0, 32'd1);
            end
        end
    endtask

    task automatic check_consecutive(input int n);
        for (int i = 1; i < n && i < log0.size(); i++)
            check($sformatf("wr%0d_cycle", i), log0[i].cyc, log0[0].cyc + 32'(i));
    endtask

    int saved_done;

    initial begin
        reset = 1'b0; start0 = 1'b1; start1 = 1'b0; sel = 1'b0;
        word_valid = 1'b0; word_data = '0; word_last = 1'b0;

        // Reset held low with start asserted: everything stays zero.
        #3;
        check("rst_ctrl", {28'd0, we0, hold0, busy0, ready0}, 32'd0);
        check("rst_flags", {30'd0, done0, err0}, 32'd0);
        check("rst_addr", {24'd0, addr0}, 32'd0);
        check("rst_wdata", {24'd0, wdata0}, 32'd0);
        check("rst_cnt", {25'd0, cnt0}, 32'd0);
        step(); step();
        check("rst_hold_start", {29'd0, busy0, hold0, ready0}, 32'd0);
        start0 = 1'b0; reset = 1'b1;
        step();
        start0 = 1'b1; step(); start0 = 1'b0;
        check("accept_ctrl", {29'd0, busy0, hold0, ready0}, 32'd7);
        check("accept_we", {31'd0, we0}, 32'd0);

        // Single word with last: four writes, then done, then hold released.
        log0.delete();
        send_word(32'h8C01_0004, 1'b1);
        check("first_we", {31'd0, we0}, 32'd1);
        repeat (4) step();
        check("fin_done", {30'd0, done0, hold0}, 32'd3);
        check("fin_cnt", {25'd0, cnt0}, 32'd1);
        step();
        check("idle_after_fin", {29'd0, done0, hold0, busy0}, 32'd0);
        check("t1_nwr", log0.size(), 32'd4);
        check_word(1'b0, 0, 8'd0, 32'h8C01_0004);
        check_consecutive(4);
        check("t1_done_cnt", done_cnt0, 32'd1);

        // Three words with a 3-cycle host stall before the second.
        log0.delete();
        start0 = 1'b1; step(); start0 = 1'b0;
        send_word(32'h1111_1111, 1'b0);
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_we", i), {30'd0, we0, ready0}, 32'd1);
            step();
        end
        send_word(32'h2222_2222, 1'b0);
        send_word(32'h3333_3333, 1'b1);
        repeat (4) step();
        check("t3_done", {31'd0, done0}, 32'd1);
        check("t3_cnt", {25'd0, cnt0}, 32'd3);
        step();
        check("t3_nwr", log0.size(), 32'd12);
        check_word(1'b0, 0, 8'd0, 32'h1111_1111);
        check_word(1'b0, 4, 8'd4, 32'h2222_2222);
        check_word(1'b0, 8, 8'd8, 32'h3333_3333);

        // BASE_ADDR=248: third word overflows, is dropped, err set, done still pulses.
        sel = 1'b1;
        log1.delete();
        start1 = 1'b1; step(); start1 = 1'b0;
        check("ovf_accept", {31'd0, ready1}, 32'd1);
        send_word(32'hA0A1_A2A3, 1'b0);
        send_word(32'hB0B1_B2B3, 1'b0);
        send_word(32'hC0C1_C2C3, 1'b1);
        check("ovf_fin", {29'd0, done1, err1, we1}, 32'd6);
        step();
        check("ovf_idle", {29'd0, done1, err1, busy1}, 32'd2);
        check("ovf_cnt", {25'd0, cnt1}, 32'd2);
        check("ovf_nwr", log1.size(), 32'd8);
        check_word(1'b1, 0, 8'd248, 32'hA0A1_A2A3);
        check_word(1'b1, 4, 8'd252, 32'hB0B1_B2B3);
        check("ovf_done_cnt", done_cnt1, 32'd1);
        check("ovf_dut0_quiet", log0.size(), 32'd12);
        // A new start clears err and word_cnt.
        start1 = 1'b1; step(); start1 = 1'b0;
        check("restart_clear", {24'd0, err1, cnt1}, 32'd0);
        send_word(32'hD0D1_D2D3, 1'b1);
        repeat (5) step();
        check("restart_idle", {31'd0, busy1}, 32'd0);
        sel = 1'b0;

        // Reset during WR2 of the second word: outputs drop at once, no done.
        log0.delete();
        saved_done = done_cnt0;
        start0 = 1'b1; step(); start0 = 1'b0;
        send_word(32'h5555_5555, 1'b0);
        send_word(32'h6666_6666, 1'b1);
        step(); step();
        check("pre_abort_wr2", {22'd0, we0, hold0, addr0}, {22'd0, 2'b11, 8'd6});
        #2 reset = 1'b0;
        #1;
        check("abort_ctrl", {28'd0, we0, hold0, busy0, ready0}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("abort_nwr", log0.size(), 32'd6);
        check("abort_no_done", done_cnt0, saved_done);
        check("abort_idle", {30'd0, busy0, done0}, 32'd0);

        // start pulsed during WR1 is ignored; addresses continue in sequence.
        log0.delete();
        start0 = 1'b1; step(); start0 = 1'b0;
        check("t6_cnt_clear", {24'd0, err0, cnt0}, 32'd0);
        send_word(32'h0403_0201, 1'b1);
        step();
        start0 = 1'b1; step(); start0 = 1'b0;
        check("t6_wr2_addr", {23'd0, we0, addr0}, {23'd0, 1'b1, 8'd2});
        step(); step();
        check("t6_done", {31'd0, done0}, 32'd1);
        step();
        check("t6_idle", {30'd0, busy0, ready0}, 32'd0);
        check("t6_nwr", log0.size(), 32'd4);
        check_word(1'b0, 0, 8'd0, 32'h0403_0201);
        check_consecutive(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU's byte-serial instruction fetch. The CPU reads each 32-bit instruction as four sequential byte reads, with the first byte landing in IR[7:0].
- This block takes 32-bit instruction words from a host stream and writes them into the 8-bit unified memory as four byte writes per word, lowest byte at the lowest address.
- It holds the CPU in reset while loading, so the CPU starts fetching from BASE_ADDR once the program is in place.

Parameters:
- ADDR_W, 8, memory address width in bits.
- BASE_ADDR, 0, first byte address written. Must be a multiple of 4.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load session. Sampled only in IDLE.
- word_valid  input  1  host has a word on word_data.
- word_data  input  32  instruction word.
- word_last  input  1  qualifies word_data as the final word of the session.
- word_ready  output  1  loader accepts a word this cycle.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- mem_we  output  1  memory write enable.
- cpu_hold  output  1  high holds the CPU in reset (ORed into the CPU reset by the top level).
- busy  output  1  session in progress.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky overflow flag. Cleared by the next accepted start.
- word_cnt  output  ADDR_W-1  number of words written in the current or last session.

Behaviour:
- Reset values (async, while reset low):
  - state=IDLE.
  - word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=0, busy=0, done=0, err=0, word_cnt=0.
  - Internal address register = BASE_ADDR.
- States: IDLE, ACCEPT, WR0, WR1, WR2, WR3, FIN.
- IDLE:
  - All outputs 0 except err and word_cnt, which hold their values.
  - start=1 -> ACCEPT. On the same edge: addr<=BASE_ADDR, word_cnt<=0, err<=0.
- ACCEPT:
  - busy=1, cpu_hold=1, word_ready=1, mem_we=0.
  - On word_valid=1, capture word_data and word_last into registers.
  - If addr <= 2^ADDR_W-4: go to WR0.
  - Otherwise: set err=1, discard the word, go to FIN.
  - word_valid=0: stay in ACCEPT indefinitely.
- WRk (k=0..3):
  - busy=1, cpu_hold=1, word_ready=0, mem_we=1.
  - mem_addr = addr, mem_wdata = captured word[8k+7:8k].
  - addr increments by 1 on every WR edge.
  - WR0->WR1->WR2->WR3 unconditionally.
  - At WR3: word_cnt increments. Then go to FIN if the captured last flag is set, else to ACCEPT.
- FIN:
  - busy=1, cpu_hold=1, done=1 for exactly this one cycle, mem_we=0. Then go to IDLE.
  - cpu_hold falls on the FIN->IDLE edge, so the CPU's first fetch cycle is the cycle after IDLE is entered.
- Throughput and latency:
  - One word per 5 cycles at minimum (ACCEPT plus 4 writes).
  - First mem_we occurs the cycle after the word handshake.
- Outputs are registered or decoded from the state register only. There is no combinational path from word_valid to mem_we.
- start outside IDLE is ignored.
- word_valid outside ACCEPT is ignored. The host must hold the word until word_ready.
- word_last on the overflowing word is still honoured: the state still goes to FIN, with err=1.
- Address never wraps. The overflow check above prevents writes past 2^ADDR_W-1.
- Reset asserted mid-session aborts immediately:
  - mem_we and cpu_hold drop asynchronously.
  - Partially written words remain in memory.
  - No done pulse is produced.
- Byte order is little-endian. This matches the fetch order: irwrite one-hot 0001 takes the byte at PC, 0010 takes PC+1, and so on.

Test Plan:
- Reset low with start=1 -> all outputs 0. Release reset, pulse start -> ACCEPT next cycle with busy=1, cpu_hold=1, word_ready=1.
- start; single word 0x8C01_0004 with last=1 -> mem writes (0,0x04), (1,0x00), (2,0x01), (3,0x8C) on 4 consecutive cycles. Then done=1 for one cycle, word_cnt=1, cpu_hold=0 next cycle.
- Three words 0x11111111, 0x22222222, 0x33333333 (last on the third), word_valid delayed 3 cycles before the second word -> 12 writes at addresses 0..11 with correct bytes, mem_we=0 throughout the stall, word_cnt=3.
- BASE_ADDR=248, ADDR_W=8, three words -> words 1 and 2 written to addresses 248..255. Third word is not written, err=1, done pulses, no write to any address <248.
- Reset pulled low during WR2 of the second word -> mem_we and cpu_hold drop in the same cycle, state=IDLE, no done pulse. A new start resets word_cnt to 0 and clears err.
- start pulsed during WR1 -> ignored: no state change, addresses continue in sequence.
